ws2812_frame_driver: RTL and testbench

- Parametrised serial LED-matrix driver. Streams one full frame from a pixel frame buffer to a WS2812-class LED chain over a single data line.
- Sits between the game engine's pixel state and the board's LED data pin.
- Adds configurable geometry, colour depth, bit timing and serpentine wiring.
- Adds a mono mode that maps 1-bit game state to fixed colours.
- Prefetches pixels so there is no gap between pixels.

---
 rtl/ws2812_frame_driver.sv | 168 ++++++++++++++++
 tb/tb_ws2812_frame_driver.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/ws2812_frame_driver.sv
// WS2812 frame driver: streams a ROWSxCOLS frame buffer to an LED chain on one data line.
// Pixels are prefetched into a hold buffer during the first bit of the previous LED so bits run back to back.
module ws2812_frame_driver #(
    parameter int ROWS       = 16,
    parameter int COLS       = 12,
    parameter int BPP        = 24,
    parameter int ADDR_W     = 8,
    parameter int TBIT       = 63,
    parameter int T0H        = 20,
    parameter int T1H        = 40,
    parameter int TRES       = 3000,
    parameter int SERPENTINE = 1,
    parameter logic [BPP-1:0] ON_COLOR  = BPP'(24'h00FF00),
    parameter logic [BPP-1:0] OFF_COLOR = '0
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic              start,
    input  logic              mono,
    output logic [ADDR_W-1:0] pix_addr,
    output logic              pix_rd,
    input  logic [BPP-1:0]    pix_data,
    output logic              dout,
    output logic              busy,
    output logic              frame_done
);
    localparam int N    = ROWS * COLS;
    localparam int CMAX = (TBIT > TRES) ? TBIT : TRES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int BW   = $clog2(BPP + 1);
    localparam int LW   = $clog2(N + 1);
    localparam int KW   = $clog2(COLS + 1);

    localparam logic [CW-1:0]     TBIT_M1 = CW'(TBIT - 1);
    localparam logic [CW-1:0]     T0H_C   = CW'(T0H);
    localparam logic [CW-1:0]     T1H_C   = CW'(T1H);
    localparam logic [CW-1:0]     TRES_M1 = CW'(TRES - 1);
    localparam logic [CW-1:0]     TRES_M2 = CW'((TRES >= 2) ? TRES - 2 : 0);
    localparam logic [BW-1:0]     BPP_M1  = BW'(BPP - 1);
    localparam logic [LW-1:0]     N_M1    = LW'(N - 1);
    localparam logic [KW-1:0]     COLS_M1 = KW'(COLS - 1);
    localparam logic [ADDR_W-1:0] COLS_A  = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] COLS_A1 = ADDR_W'(COLS - 1);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, LATCH} state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [BW-1:0]     bit_q;
    logic [LW-1:0]     led_q;
    logic [KW-1:0]     col_q, col_d;
    logic              odd_q, odd_d;
    logic [ADDR_W-1:0] base_q, base_d, addr_d, addr_q;
    logic [BPP-1:0]    shift_q, hold_q;
    logic              mono_q, pf_rd_q, pf_q;
    logic              dout_q, busy_q, done_q, rd_q;
    logic              issue_d;

    function automatic logic [BPP-1:0] colour(input logic [BPP-1:0] x, input logic m);
        return m ? (x[0] ? ON_COLOR : OFF_COLOR) : x;
    endfunction

    // Row/column walk of the LED chain; base_q tracks row*COLS so no multiplier is needed.
    always_comb begin
        col_d  = col_q + 1'b1;
        odd_d  = odd_q;
        base_d = base_q;
        if (col_q == COLS_M1) begin
            col_d  = '0;
            odd_d  = ~odd_q;
            base_d = base_q + COLS_A;
        end
        if (SERPENTINE != 0 && odd_q) addr_d = base_q + COLS_A1 - ADDR_W'(col_q);
        else                          addr_d = base_q + ADDR_W'(col_q);
        issue_d = (state_q == IDLE && start) ||
                  (state_q == LOAD && N > 1) ||
                  (state_q == SEND && cnt_q == TBIT_M1 && bit_q == BPP_M1 && int'(led_q) < N - 2);
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            led_q   <= '0;
            col_q   <= '0;
            odd_q   <= 1'b0;
            base_q  <= '0;
            addr_q  <= '0;
            shift_q <= '0;
            hold_q  <= '0;
            mono_q  <= 1'b0;
            pf_rd_q <= 1'b0;
            pf_q    <= 1'b0;
            dout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            rd_q    <= 1'b0;
            done_q  <= 1'b0;
            dout_q  <= 1'b0;
            pf_rd_q <= issue_d && state_q != IDLE;
            pf_q    <= pf_rd_q;
            if (pf_q) hold_q <= colour(pix_data, mono_q);
            case (state_q)
                IDLE: if (start) begin
                    state_q <= FETCH;
                    busy_q  <= 1'b1;
                    mono_q  <= mono;
                end
                FETCH: state_q <= LOAD;
                LOAD: begin
                    shift_q <= colour(pix_data, mono_q);
                    cnt_q   <= '0;
                    bit_q   <= '0;
                    led_q   <= '0;
                    state_q <= SEND;
                end
                SEND: begin
                    dout_q <= cnt_q < (shift_q[BPP-1] ? T1H_C : T0H_C);
                    if (cnt_q != TBIT_M1) begin
                        cnt_q <= cnt_q + 1'b1;
                    end else begin
                        cnt_q <= '0;
                        if (bit_q != BPP_M1) begin
                            bit_q   <= bit_q + 1'b1;
                            shift_q <= shift_q << 1;
                        end else if (led_q == N_M1) begin
                            state_q <= LATCH;
                            done_q  <= (TRES == 1);
                        end else begin
                            bit_q   <= '0;
                            led_q   <= led_q + 1'b1;
                            shift_q <= hold_q;
                        end
                    end
                end
                LATCH: begin
                    if (cnt_q == TRES_M1) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        col_q   <= '0;
                        odd_q   <= 1'b0;
                        base_q  <= '0;
                    end else begin
                        cnt_q  <= cnt_q + 1'b1;
                        done_q <= (cnt_q == TRES_M2);
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (issue_d) begin
                rd_q   <= 1'b1;
                addr_q <= addr_d;
                col_q  <= col_d;
                odd_q  <= odd_d;
                base_q <= base_d;
            end
        end
    end

    assign dout       = dout_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign pix_rd     = rd_q;
    assign pix_addr   = addr_q;
endmodule

// File: tb/tb_ws2812_frame_driver.sv
// Directed bench: a serpentine and a linear driver run side by side on the same start/mono stimulus,
// each with its own registered frame-buffer model; waveforms, read order and frame timing are checked.
module tb_ws2812_frame_driver;
    localparam int N = 6, FLEN = 2 + N * 4 * 8 + 10;   // 204

    logic clk = 0, rst_n = 0, start = 0, mono = 0;
    logic [7:0] addr1, addr0;
    logic rd1, rd0, dout1, dout0, busy1, busy0, fd1, fd0;
    logic [3:0] pd1 = 0, pd0 = 0;
    int n_run = 0, n_fail = 0;
    int ord [2][6] = '{'{0, 1, 2, 3, 4, 5}, '{0, 1, 2, 5, 4, 3}};

    always #5 clk = ~clk;

    ws2812_frame_driver #(.ROWS(2), .COLS(3), .BPP(4), .ADDR_W(8), .TBIT(8), .T0H(2), .T1H(5),
        .TRES(10), .SERPENTINE(1), .ON_COLOR(4'hA), .OFF_COLOR(4'h1)) u_serp (
        .CLOCK_50(clk), .reset_n(rst_n), .start(start), .mono(mono), .pix_addr(addr1),
        .pix_rd(rd1), .pix_data(pd1), .dout(dout1), .busy(busy1), .frame_done(fd1));

    ws2812_frame_driver #(.ROWS(2), .COLS(3), .BPP(4), .ADDR_W(8), .TBIT(8), .T0H(2), .T1H(5),
        .TRES(10), .SERPENTINE(0), .ON_COLOR(4'hA), .OFF_COLOR(4'h1)) u_lin (
        .CLOCK_50(clk), .reset_n(rst_n), .start(start), .mono(mono), .pix_addr(addr0),
        .pix_rd(rd0), .pix_data(pd0), .dout(dout0), .busy(busy0), .frame_done(fd0));

    function automatic logic [3:0] mem(input int a);
        return 4'(a + 3);
    endfunction

    function automatic logic [3:0] cl(input logic [3:0] v, input logic m);
        return m ? (v[0] ? 4'hA : 4'h1) : v;
    endfunction

    always @(posedge clk) begin
        if (rd1) pd1 <= mem(int'(addr1));
        if (rd0) pd0 <= mem(int'(addr0));
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle(input int n, input string tag);
        int act = 0;
        repeat (n) begin
            @(negedge clk);
            if (dout1 || dout0 || busy1 || busy0 || fd1 || fd0 || rd1 || rd0) act++;
        end
        chk(tag, act, 0);
    endtask

    // One frame from the start edge E0 to the first IDLE cycle; t counts cycles after E0.
    task automatic do_frame(input logic m, input bit hold, input string tag);
        int rdn[2], rderr[2], derr[2], rise[2], dn[2], dt[2], berr[2], ordv[2], ordx[2];
        for (int s = 0; s < 2; s++) begin
            rdn[s] = 0; rderr[s] = 0; derr[s] = 0; rise[s] = -1;
            dn[s] = 0; dt[s] = -1; berr[s] = 0; ordv[s] = 0; ordx[s] = 0;
            for (int i = 0; i < N; i++) ordx[s] = ordx[s] * 8 + ord[s][i];
        end
        start = 1; mono = m;
        @(posedge clk);
        @(negedge clk);
        if (!hold) start = 0;
        mono = ~m;
        for (int t = 0; t <= FLEN; t++) begin
            if (t == 50) start = 1;
            if (t == 51 && !hold) start = 0;
            for (int s = 0; s < 2; s++) begin
                logic dd, rr, ff, bb, e;
                logic [7:0] aa;
                int k, rt;
                dd = s ? dout1 : dout0; rr = s ? rd1 : rd0; ff = s ? fd1 : fd0;
                bb = s ? busy1 : busy0; aa = s ? addr1 : addr0;
                if (rr) begin
                    rt = (rdn[s] == 0) ? 0 : 2 + 32 * (rdn[s] - 1);
                    if (t != rt) rderr[s]++;
                    ordv[s] = ordv[s] * 8 + int'(aa);
                    rdn[s]++;
                end
                e = 1'b0;
                if (t >= 3 && t <= 194) begin
                    logic [3:0] v;
                    k = t - 3;
                    v = cl(mem(ord[s][k / 32]), m);
                    e = (k % 8) < (v[3 - (k / 8) % 4] ? 5 : 2);
                end
                if (dd !== e) derr[s]++;
                if (dd && rise[s] < 0) rise[s] = t;
                if (ff) begin dn[s]++; dt[s] = t; end
                if (bb !== (t < FLEN)) berr[s]++;
            end
            if (t < FLEN) @(negedge clk);
        end
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("%s/s%0d rd_order", tag, s), ordv[s], ordx[s]);
            chk($sformatf("%s/s%0d rd_count", tag, s), rdn[s], N);
            chk($sformatf("%s/s%0d rd_timing", tag, s), rderr[s], 0);
            chk($sformatf("%s/s%0d dout_wave", tag, s), derr[s], 0);
            chk($sformatf("%s/s%0d first_rise", tag, s), rise[s], 3);
            chk($sformatf("%s/s%0d done_count", tag, s), dn[s], 1);
            chk($sformatf("%s/s%0d done_time", tag, s), dt[s], FLEN - 1);
            chk($sformatf("%s/s%0d busy_wave", tag, s), berr[s], 0);
        end
    endtask

    initial begin
        int act = 0, w = 0;
        repeat (3) begin
            @(negedge clk);
            if (dout1 || dout0 || busy1 || busy0 || fd1 || fd0 || rd1 || rd0) act++;
            if (addr1 != 0 || addr0 != 0) act++;
        end
        chk("reset_outputs", act, 0);
        rst_n = 1;
        idle(20, "no_start_idle");

        do_frame(1'b0, 1'b0, "raw");
        idle(5, "raw_tail");
        do_frame(1'b1, 1'b0, "mono");
        idle(5, "mono_tail");

        do_frame(1'b0, 1'b1, "b2b_1");
        do_frame(1'b0, 1'b0, "b2b_2");
        idle(30, "b2b_tail");

        start = 1;
        @(posedge clk);
        @(negedge clk);
        start = 0;
        while (!dout1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("rst_wait_high", int'(dout1), 1);
        rst_n = 0;
        #1;
        chk("rst_dout_async", int'(dout1), 0);
        chk("rst_busy_async", int'(busy1 | busy0), 0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_rd_held", int'(rd1 | rd0 | fd1 | fd0), 0);
        rst_n = 1;
        idle(5, "post_rst_idle");
        do_frame(1'b0, 1'b0, "after_rst");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
